// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: single-outstanding-request instruction fetch stage with IF/ID register and skid buffer.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   imem_req, imem_addr         instruction memory request and word-aligned byte address
//   imem_ready, imem_rdata      completion strobe and instruction word
//   id_stall                    decode cannot accept a new instruction
//   redirect_valid, redirect_pc taken branch/jump from decode and its target
//   Instruction, PC_plus_4      IF/ID register contents
//   if_valid                    IF/ID register holds a live instruction
//   fetch_count                 instructions delivered to decode
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        id_stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] Instruction,
    output logic [31:0] PC_plus_4,
    output logic        if_valid,
    output logic [31:0] fetch_count
);
    typedef enum logic [1:0] {FETCH, BUFFERED, DISCARD} state_t;

    state_t      r_state, w_state_n;
    logic [31:0] r_pc, r_req_addr, r_skid_instr, r_skid_pc4, r_instr, r_pc4, r_count;
    logic        r_valid;
    logic [31:0] w_pc_n, w_req_addr_n, w_skid_instr_n, w_skid_pc4_n, w_instr_n, w_pc4_n, w_count_n;
    logic        w_valid_n;
    logic        w_free;
    logic [31:0] w_redir_pc, w_next_addr;

    assign imem_req    = r_state != BUFFERED;
    assign imem_addr   = r_req_addr;
    assign Instruction = r_instr;
    assign PC_plus_4   = r_pc4;
    assign if_valid    = r_valid;
    assign fetch_count = r_count;

    assign w_free      = !r_valid || !id_stall;
    assign w_redir_pc  = redirect_pc & ~32'h3;
    assign w_next_addr = r_req_addr + 32'd4;

    always_comb begin
        w_state_n      = r_state;
        w_pc_n         = r_pc;
        w_req_addr_n   = r_req_addr;
        w_skid_instr_n = r_skid_instr;
        w_skid_pc4_n   = r_skid_pc4;
        w_instr_n      = r_instr;
        w_pc4_n        = r_pc4;
        w_count_n      = r_count;
        // a consumed instruction drops out unless something new is loaded below
        w_valid_n      = r_valid && id_stall;
        if (redirect_valid) begin
            w_valid_n = 1'b0;
            w_pc_n    = w_redir_pc;
            // an outstanding request cannot be withdrawn, so its data must be drained first
            if (r_state != BUFFERED && !imem_ready) begin
                w_state_n = DISCARD;
            end else begin
                w_state_n    = FETCH;
                w_req_addr_n = w_redir_pc;
            end
        end else begin
            case (r_state)
                FETCH: begin
                    if (imem_ready) begin
                        w_pc_n       = w_next_addr;
                        w_req_addr_n = w_next_addr;
                        if (w_free) begin
                            w_instr_n = imem_rdata;
                            w_pc4_n   = w_next_addr;
                            w_valid_n = 1'b1;
                            w_count_n = r_count + 32'd1;
                        end else begin
                            w_skid_instr_n = imem_rdata;
                            w_skid_pc4_n   = w_next_addr;
                            w_state_n      = BUFFERED;
                        end
                    end
                end
                BUFFERED: begin
                    if (!id_stall) begin
                        w_instr_n = r_skid_instr;
                        w_pc4_n   = r_skid_pc4;
                        w_valid_n = 1'b1;
                        w_count_n = r_count + 32'd1;
                        w_state_n = FETCH;
                    end
                end
                default: begin
                    if (imem_ready) begin
                        w_req_addr_n = r_pc;
                        w_state_n    = FETCH;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= FETCH;
            r_pc         <= RESET_PC;
            r_req_addr   <= RESET_PC;
            r_skid_instr <= 32'd0;
            r_skid_pc4   <= 32'd0;
            r_instr      <= 32'd0;
            r_pc4        <= 32'd0;
            r_valid      <= 1'b0;
            r_count      <= 32'd0;
        end else begin
            r_state      <= w_state_n;
            r_pc         <= w_pc_n;
            r_req_addr   <= w_req_addr_n;
            r_skid_instr <= w_skid_instr_n;
            r_skid_pc4   <= w_skid_pc4_n;
            r_instr      <= w_instr_n;
            r_pc4        <= w_pc4_n;
            r_valid      <= w_valid_n;
            r_count      <= w_count_n;
        end
    end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed bench for instruction_fetch_unit, including a second instance reset near the top of memory.
module tb_instruction_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req, imem_ready = 1'b0, id_stall = 1'b0, redirect_valid = 1'b0, if_valid;
    logic [31:0] imem_addr, imem_rdata, redirect_pc = 32'd0, Instruction, PC_plus_4, fetch_count;
    logic        imem_req2, if_valid2;
    logic [31:0] imem_addr2, imem_rdata2, Instruction2, PC_plus_42, fetch_count2;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    assign imem_rdata  = {16'hC0DE, imem_addr[15:0]};
    assign imem_rdata2 = {16'hC0DE, imem_addr2[15:0]};

    instruction_fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata), .id_stall(id_stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .Instruction(Instruction), .PC_plus_4(PC_plus_4), .if_valid(if_valid),
        .fetch_count(fetch_count)
    );

    instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_ready(1'b1), .imem_rdata(imem_rdata2), .id_stall(1'b0),
        .redirect_valid(1'b0), .redirect_pc(32'd0),
        .Instruction(Instruction2), .PC_plus_4(PC_plus_42), .if_valid(if_valid2),
        .fetch_count(fetch_count2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #12;
        check("rst_valid", if_valid, 0);
        check("rst_instr", Instruction, 0);
        check("rst_pc4", PC_plus_4, 0);
        check("rst_count", fetch_count, 0);
        check("rst_addr", imem_addr, 0);
        check("rst_addr2", imem_addr2, 32'hFFFF_FFFC);
        @(negedge clk);
        rst_n = 1'b1;
        check("post_rst_req", imem_req, 1);
        imem_ready = 1'b1;
        tick();
        check("f0_instr", Instruction, 32'hC0DE_0000);
        check("f0_pc4", PC_plus_4, 4);
        check("f0_valid", if_valid, 1);
        check("f0_addr", imem_addr, 4);
        check("wrap_pc4", PC_plus_42, 0);
        check("wrap_instr", Instruction2, 32'hC0DE_FFFC);
        check("wrap_addr", imem_addr2, 0);
        tick();
        check("f1_pc4", PC_plus_4, 8);
        check("f1_addr", imem_addr, 8);
        check("wrap2_pc4", PC_plus_42, 4);
        tick();
        check("f2_pc4", PC_plus_4, 12);
        check("f2_instr", Instruction, 32'hC0DE_0008);
        check("f2_count", fetch_count, 3);
        id_stall = 1'b1;
        tick();
        check("buf_req", imem_req, 0);
        check("buf_instr", Instruction, 32'hC0DE_0008);
        check("buf_count", fetch_count, 3);
        tick();
        check("buf2_req", imem_req, 0);
        check("buf2_pc4", PC_plus_4, 12);
        tick();
        check("buf3_req", imem_req, 0);
        check("buf3_addr", imem_addr, 16);
        id_stall = 1'b0;
        tick();
        check("skid_instr", Instruction, 32'hC0DE_000C);
        check("skid_pc4", PC_plus_4, 16);
        check("skid_count", fetch_count, 4);
        check("skid_req", imem_req, 1);
        tick();
        check("after_skid_instr", Instruction, 32'hC0DE_0010);
        check("after_skid_count", fetch_count, 5);
        imem_ready = 1'b0;
        tick();
        check("consume_valid", if_valid, 0);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0103;
        tick();
        check("disc_addr", imem_addr, 20);
        check("disc_req", imem_req, 1);
        redirect_valid = 1'b0;
        tick();
        check("disc_hold_addr", imem_addr, 20);
        imem_ready = 1'b1;
        tick();
        check("disc_drop_count", fetch_count, 5);
        check("disc_drop_valid", if_valid, 0);
        check("disc_new_addr", imem_addr, 32'h100);
        tick();
        check("tgt_instr", Instruction, 32'hC0DE_0100);
        check("tgt_pc4", PC_plus_4, 32'h104);
        check("tgt_count", fetch_count, 6);
        redirect_valid = 1'b1;
        redirect_pc = 32'h200;
        id_stall = 1'b1;
        tick();
        check("pri_valid", if_valid, 0);
        check("pri_count", fetch_count, 6);
        check("pri_addr", imem_addr, 32'h200);
        redirect_valid = 1'b0;
        id_stall = 1'b0;
        tick();
        check("pri_next_instr", Instruction, 32'hC0DE_0200);
        check("pri_next_count", fetch_count, 7);
        imem_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h300;
        tick();
        redirect_pc = 32'h404;
        tick();
        check("latest_hold_addr", imem_addr, 32'h204);
        redirect_valid = 1'b0;
        imem_ready = 1'b1;
        tick();
        check("latest_addr", imem_addr, 32'h404);
        check("latest_count", fetch_count, 7);
        imem_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h500;
        tick();
        redirect_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_valid", if_valid, 0);
        check("async_instr", Instruction, 0);
        check("async_pc4", PC_plus_4, 0);
        check("async_count", fetch_count, 0);
        check("async_addr", imem_addr, 0);
        check("async_req", imem_req, 1);
        #1;
        rst_n = 1'b1;
        imem_ready = 1'b1;
        tick();
        check("rerst_instr", Instruction, 32'hC0DE_0000);
        check("rerst_pc4", PC_plus_4, 4);
        check("rerst_count", fetch_count, 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port imem_req, output, 1 bit: instruction memory read request.
REQ-005 SHALL have port imem_addr, output, 32 bits: byte address of the request, with bits [1:0] always 0.
REQ-006 SHALL have port imem_ready, input, 1 bit: the request completes in the cycle imem_req=1 and imem_ready=1.
REQ-007 SHALL have port imem_rdata, input, 32 bits: instruction word, valid only in the completing cycle.
REQ-008 SHALL have port id_stall, input, 1 bit: the decode stage cannot accept a new instruction.
REQ-009 SHALL have port redirect_valid, input, 1 bit: a branch or jump was taken in decode.
REQ-010 SHALL have port redirect_pc, input, 32 bits: target address; bits [1:0] are ignored and treated as 0.
REQ-011 SHALL have port Instruction, output, 32 bits: IF/ID register instruction, feeding decode.
REQ-012 SHALL have port PC_plus_4, output, 32 bits: fetch address of Instruction plus 4.
REQ-013 SHALL have port if_valid, output, 1 bit: Instruction and PC_plus_4 hold a live instruction.
REQ-014 SHALL have port fetch_count, output, 32 bits: number of instructions delivered to decode.

Function
REQ-015 SHALL hold internal registers pc (32-bit), req_addr (32-bit), a skid buffer (32-bit instruction plus 32-bit PC_plus_4), and a 3-state FSM: FETCH, BUFFERED, DISCARD.
REQ-016 SHALL drive imem_req=1 in FETCH and DISCARD and imem_req=0 in BUFFERED, with imem_addr=req_addr in all states.
REQ-017 SHALL keep req_addr stable while imem_req=1 and imem_ready=0 (no request withdrawal or address change mid-request).
REQ-018 SHALL treat the IF/ID register as free when if_valid=0 or id_stall=0.
REQ-019 In FETCH, when the request completes and IF/ID is free, SHALL load Instruction<=imem_rdata, PC_plus_4<=req_addr+4, and if_valid<=1, advance pc and req_addr to req_addr+4, and increment fetch_count.
REQ-020 In FETCH, when the request completes and IF/ID is not free, SHALL capture rdata and req_addr+4 into the skid buffer, set pc and req_addr to req_addr+4, and go to BUFFERED.
REQ-021 In BUFFERED, when id_stall=0, SHALL move the skid buffer into IF/ID, keep if_valid=1, increment fetch_count, and go to FETCH; otherwise SHALL hold all state.
REQ-022 When the decode stage consumes an instruction (if_valid=1, id_stall=0) and no new instruction is loaded that cycle, SHALL clear if_valid.
REQ-023 SHALL add 32 bits modulo 2^32, so address 32'hFFFF_FFFC+4 wraps to 0; fetch_count SHALL also wrap at 2^32.
REQ-024 redirect_valid SHALL take priority over id_stall and over any completion in the same cycle, and SHALL clear if_valid next cycle.
REQ-025 On redirect_valid, SHALL discard any instruction completing in that cycle and any skid-buffer contents, and SHALL set pc<={redirect_pc[31:2],2'b00}.
REQ-026 On redirect in FETCH with imem_ready=0 (request outstanding), SHALL go to DISCARD with req_addr unchanged.
REQ-027 On redirect otherwise, SHALL go to FETCH with req_addr=new pc.
REQ-028 In DISCARD, SHALL drop the returning data without updating IF/ID or fetch_count; on imem_ready=1, SHALL set req_addr<=pc and go to FETCH.
REQ-029 A further redirect while in DISCARD SHALL update only pc, and the latest redirect wins.
REQ-030 Fetch latency SHALL be 1 cycle from completion to if_valid=1 when imem_ready is asserted combinationally.
REQ-031 Sustained throughput SHALL be one instruction per cycle when imem_ready=1 and id_stall=0.

Reset
REQ-032 While rst_n=0, SHALL immediately force state=FETCH, pc=req_addr=RESET_PC, if_valid=0, Instruction=0, PC_plus_4=0, fetch_count=0, and skid buffer=0.
REQ-033 Reset asserted mid-request SHALL abandon the request; the first post-reset request SHALL be to RESET_PC.
REQ-034 After reset deassertion, imem_req SHALL be 1 in the first cycle.

Verification
REQ-035 Reset release with imem_ready=1 and rdata=mem[addr>>2] -> addresses 0,4,8 are requested on consecutive cycles, PC_plus_4=4,8,12, and fetch_count=3 after 3 deliveries.
REQ-036 id_stall=1 for 3 cycles with a completion landing while if_valid=1 -> state=BUFFERED, imem_req=0, and Instruction unchanged; on stall release the skid word appears with no loss or duplication.
REQ-037 redirect_valid with redirect_pc=32'h0000_0103 while imem_ready=0 -> DISCARD; the stale word is dropped, next imem_addr=32'h0000_0100, and fetch_count is unchanged by the stale word.
REQ-038 redirect_valid, imem_ready=1, and id_stall=1 in the same cycle -> if_valid=0 next cycle, the returned word is dropped, and imem_addr=target.
REQ-039 RESET_PC=32'hFFFF_FFFC with imem_ready=1 -> second request is to 32'h0000_0000 and PC_plus_4=0 for the first instruction.
REQ-040 rst_n pulsed low asynchronously mid-DISCARD -> outputs return to reset values before the next clk edge, and the next imem_addr=RESET_PC.
